// File: rtl/seq_rca_adder.sv
// Multi-cycle ripple-carry adder/subtractor: WIDTH-bit operands are added CHUNK
// bits per clock through a CHUNK-bit full-adder chain with a registered inter-chunk carry.
module seq_rca_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS  = WIDTH / CHUNK;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [STEP_W-1:0]  step_q, step_d;

  logic [CHUNK-1:0]   a_sl, b_sl, s_sl;
  logic [CHUNK:0]     c;
  logic               last;

  // Operand slice for the current step, then the CHUNK-bit ripple chain.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    s_sl = '0;
    c    = '0;
    for (int unsigned s = 0; s < STEPS; s++) begin
      if (step_q == STEP_W'(s)) begin
        a_sl = a_q[s*CHUNK +: CHUNK];
        b_sl = b_q[s*CHUNK +: CHUNK];
      end
    end
    c[0] = carry_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s_sl[i]   = a_sl[i] ^ b_sl[i] ^ c[i];
      c[i+1]    = (a_sl[i] & b_sl[i]) | (c[i] & (a_sl[i] ^ b_sl[i]));
    end
  end

  assign last = (step_q == STEP_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  // Datapath next-state; subtraction is A + ~B + 1 with the +1 as initial carry.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          step_d  = '0;
        end
      end
      RUN: begin
        for (int unsigned s = 0; s < STEPS; s++) begin
          if (step_q == STEP_W'(s)) sum_d[s*CHUNK +: CHUNK] = s_sl;
        end
        carry_d = c[CHUNK];
        if (last) begin
          cout_d = c[CHUNK];
          ovf_d  = c[CHUNK] ^ c[CHUNK-1];
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
    end
  end

endmodule
